// File: rtl/instr_mem_pkg.sv
// Shared types and sizing helpers for the instruction memory responder.
// Used by instr_mem, imem_loader and instr_mem_if.
package imem_pkg;

   localparam logic [31:0] NOP_DEFAULT = 32'h0000_0000;

   typedef enum logic {
      LOAD = 1'b0,
      RUN  = 1'b1
   } imem_state_e;

   // Word index width; the count needs one more bit to represent DEPTH itself.
   function automatic int idx_w(input int depth);
      return $clog2(depth);
   endfunction

   function automatic int cnt_w(input int depth);
      return $clog2(depth) + 1;
   endfunction

endpackage

// File: rtl/instr_mem_if.sv
// Bus bundle for instr_mem: fetch read port plus program load port.
// The master side drives addresses and load words; the slave side is the memory.
interface instr_mem_if #(
   parameter int DEPTH = 256
);
   import imem_pkg::*;

   logic [31:0]             iaddr;
   logic [31:0]             idata;
   logic                    ld_valid;
   logic                    ld_ready;
   logic [31:0]             ld_data;
   logic                    ld_last;
   logic [cnt_w(DEPTH)-1:0] ld_count;
   logic                    core_reset;
   logic                    fault;

   modport master (
      output iaddr, ld_valid, ld_data, ld_last,
      input  idata, ld_ready, ld_count, core_reset, fault
   );

   modport slave (
      input  iaddr, ld_valid, ld_data, ld_last,
      output idata, ld_ready, ld_count, core_reset, fault
   );

endinterface

// File: rtl/instr_mem_loader.sv
// Load-phase controller for instr_mem: LOAD/RUN FSM, write pointer, word count
// and the registered core reset that releases the pipeline once the program is in.
module imem_loader
   import imem_pkg::*;
#(
   parameter int DEPTH = 256
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    ld_valid,
   input  logic                    ld_last,
   output logic                    ld_ready,
   output logic [cnt_w(DEPTH)-1:0] ld_count,
   output logic                    core_reset,
   output logic                    we,
   output logic [idx_w(DEPTH)-1:0] waddr,
   output imem_state_e             state
);

   localparam int IW = idx_w(DEPTH);
   localparam int CW = cnt_w(DEPTH);
   localparam logic [IW-1:0] LAST_PTR = IW'(DEPTH - 1);
   localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

   imem_state_e   state_q, state_d;
   logic [IW-1:0] ptr_q, ptr_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          core_reset_q;
   logic          accept;

   always_comb begin
      state_d  = state_q;
      ptr_d    = ptr_q;
      cnt_d    = cnt_q;
      ld_ready = 1'b0;
      accept   = 1'b0;
      if (state_q == LOAD) begin
         ld_ready = 1'b1;
         accept   = ld_valid;
         if (accept) begin
            if (cnt_q != FULL_CNT) cnt_d = cnt_q + CW'(1);
            // The pointer parks on the last slot instead of wrapping.
            if (ptr_q != LAST_PTR) ptr_d = ptr_q + IW'(1);
            if (ld_last || (ptr_q == LAST_PTR)) state_d = RUN;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= LOAD;
         ptr_q        <= '0;
         cnt_q        <= '0;
         core_reset_q <= 1'b1;
      end else begin
         state_q      <= state_d;
         ptr_q        <= ptr_d;
         cnt_q        <= cnt_d;
         core_reset_q <= (state_d == LOAD);
      end
   end

   // Reset wins over a coincident handshake: that word must not land in the array.
   assign we         = accept && !reset;
   assign waddr      = ptr_q;
   assign ld_count   = cnt_q;
   assign core_reset = core_reset_q;
   assign state      = state_q;

endmodule

// File: rtl/instr_mem.sv
// Instruction memory responder: loads a program over a valid/ready port, then serves
// combinational fetch reads masked by the loaded length. Optional fault logic: IMEM_FAULT_EN.
module instr_mem
   import imem_pkg::*;
#(
   parameter int          DEPTH    = 256,
   parameter logic [31:0] NOP_WORD = NOP_DEFAULT
) (
   input logic        clk,
   input logic        reset,
   instr_mem_if.slave bus
);

   localparam int IW = idx_w(DEPTH);
   localparam int CW = cnt_w(DEPTH);

   logic [31:0]   mem [DEPTH];
   imem_state_e   state;
   logic          we;
   logic [IW-1:0] waddr;
   logic [CW-1:0] ld_count;
   logic          core_reset;
   logic          ld_ready;
   logic [IW-1:0] idx;
   logic          hit;

   imem_loader #(
      .DEPTH (DEPTH)
   ) u_loader (
      .clk        (clk),
      .reset      (reset),
      .ld_valid   (bus.ld_valid),
      .ld_last    (bus.ld_last),
      .ld_ready   (ld_ready),
      .ld_count   (ld_count),
      .core_reset (core_reset),
      .we         (we),
      .waddr      (waddr),
      .state      (state)
   );

   assign bus.ld_ready   = ld_ready;
   assign bus.ld_count   = ld_count;
   assign bus.core_reset = core_reset;

   always_ff @(posedge clk) begin
      if (we) mem[waddr] <= bus.ld_data;
   end

   // Words beyond the loaded length read as NOP so stale contents never execute.
   assign idx = bus.iaddr[IW+1:2];
   assign hit = (state == RUN) && ({1'b0, idx} < ld_count);

`ifdef IMEM_FAULT_EN
   logic oob;
   logic misalign;
   logic fault_q;

   assign oob      = |bus.iaddr[31:IW+2];
   assign misalign = |bus.iaddr[1:0];

   always_ff @(posedge clk) begin
      if (reset) begin
         fault_q <= 1'b0;
      end else if ((state == RUN) && !core_reset && (misalign || oob || !hit)) begin
         fault_q <= 1'b1;
      end
   end

   assign bus.idata = (hit && !oob) ? mem[idx] : NOP_WORD;
   assign bus.fault = fault_q;
`else
   logic unused_addr;

   assign unused_addr = ^{bus.iaddr[31:IW+2], bus.iaddr[1:0]};
   assign bus.idata   = hit ? mem[idx] : NOP_WORD;
   assign bus.fault   = 1'b0;
`endif

endmodule

// File: tb/tb_instr_mem.sv
// Scoreboard bench for instr_mem: a DEPTH=256 and a DEPTH=4 instance driven with
// directed load/fetch vectors; a negedge monitor pops and compares expectations.
module tb_instr_mem;
   import imem_pkg::*;

   localparam int K_IDATA = 0;
   localparam int K_CNT   = 1;
   localparam int K_RDY   = 2;
   localparam int K_CRST  = 3;
   localparam int K_FAULT = 4;

`ifdef IMEM_FAULT_EN
   localparam logic FE = 1'b1;
`else
   localparam logic FE = 1'b0;
`endif

   typedef struct {
      string       name;
      int          sel;
      int          kind;
      logic [31:0] exp;
   } chk_t;

   chk_t sb[$];
   int   n_vec = 0;
   int   n_bad = 0;

   logic clk = 1'b0;
   logic rst256;
   logic rst4;

   always #5 clk = ~clk;

   instr_mem_if #(.DEPTH(256)) bus256 ();
   instr_mem_if #(.DEPTH(4))   bus4 ();

   instr_mem #(.DEPTH(256)) u_mem256 (
      .clk   (clk),
      .reset (rst256),
      .bus   (bus256.slave)
   );

   instr_mem #(.DEPTH(4)) u_mem4 (
      .clk   (clk),
      .reset (rst4),
      .bus   (bus4.slave)
   );

   function automatic logic [31:0] actual(input int sel, input int kind);
      logic [31:0] r;
      r = 32'hxxxx_xxxx;
      if (sel == 0) begin
         case (kind)
            K_IDATA: r = bus256.idata;
            K_CNT:   r = 32'(bus256.ld_count);
            K_RDY:   r = 32'(bus256.ld_ready);
            K_CRST:  r = 32'(bus256.core_reset);
            K_FAULT: r = 32'(bus256.fault);
            default: r = 32'hxxxx_xxxx;
         endcase
      end else begin
         case (kind)
            K_IDATA: r = bus4.idata;
            K_CNT:   r = 32'(bus4.ld_count);
            K_RDY:   r = 32'(bus4.ld_ready);
            K_CRST:  r = 32'(bus4.core_reset);
            K_FAULT: r = 32'(bus4.fault);
            default: r = 32'hxxxx_xxxx;
         endcase
      end
      return r;
   endfunction

   // Monitor: every queued expectation is checked at the falling edge.
   always @(negedge clk) begin
      while (sb.size() > 0) begin
         chk_t        c;
         logic [31:0] a;
         c = sb.pop_front();
         a = actual(c.sel, c.kind);
         n_vec++;
         if (a !== c.exp) begin
            n_bad++;
            $display("FAIL %s: got %h, want %h", c.name, a, c.exp);
         end
      end
   end

   task automatic want(input int sel, input int kind, input logic [31:0] e, input string nm);
      chk_t c;
      c.name = nm;
      c.sel  = sel;
      c.kind = kind;
      c.exp  = e;
      sb.push_back(c);
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic drv256(input logic v, input logic [31:0] d, input logic l);
      bus256.ld_valid = v;
      bus256.ld_data  = d;
      bus256.ld_last  = l;
   endtask

   task automatic drv4(input logic v, input logic [31:0] d, input logic l);
      bus4.ld_valid = v;
      bus4.ld_data  = d;
      bus4.ld_last  = l;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, want finish");
      $fatal(1, "watchdog");
   end

   localparam int THR_CNT [6] = '{0, 1, 1, 2, 2, 3};

   initial begin
      rst256 = 1'b1;
      rst4   = 1'b1;
      bus256.iaddr = 32'h0;
      bus4.iaddr   = 32'h0;
      drv256(1'b0, 32'h0, 1'b0);
      drv4(1'b0, 32'h0, 1'b0);
      tick;

      // Basic three-word load, then fetches
      rst256 = 1'b0;
      drv256(1'b1, 32'h1111_1111, 1'b0);
      want(0, K_RDY, 32'd1, "rst_ready");
      want(0, K_CNT, 32'd0, "rst_count");
      want(0, K_CRST, 32'd1, "rst_core_reset");
      want(0, K_FAULT, 32'd0, "rst_fault");
      want(0, K_IDATA, 32'h0, "rst_idata");
      tick;
      drv256(1'b1, 32'h2222_2222, 1'b0);
      want(0, K_CNT, 32'd1, "ld3_cnt1");
      want(0, K_IDATA, 32'h0, "ld3_idata_load");
      tick;
      drv256(1'b1, 32'h3333_3333, 1'b1);
      want(0, K_CNT, 32'd2, "ld3_cnt2");
      want(0, K_CRST, 32'd1, "ld3_crst_hold");
      tick;
      drv256(1'b1, 32'hDEAD_BEEF, 1'b1);
      want(0, K_CNT, 32'd3, "ld3_cnt3");
      want(0, K_CRST, 32'd0, "ld3_crst_fall");
      want(0, K_RDY, 32'd0, "ld3_ready_low");
      want(0, K_IDATA, 32'h1111_1111, "ld3_addr0");
      tick;
      drv256(1'b0, 32'h0, 1'b0);
      bus256.iaddr = 32'd4;
      want(0, K_CNT, 32'd3, "run_ignores_valid");
      want(0, K_IDATA, 32'h2222_2222, "ld3_addr4");
      tick;
      bus256.iaddr = 32'd8;
      want(0, K_IDATA, 32'h3333_3333, "ld3_addr8");
      tick;
      bus256.iaddr = 32'd12;
      want(0, K_IDATA, 32'h0, "ld3_addr12_nop");
      tick;
      bus256.iaddr = 32'd0;
      want(0, K_FAULT, 32'(FE), "ld3_fault_past_end");
      want(0, K_IDATA, 32'h1111_1111, "ld3_addr0_intact");
      tick;

      // Throttled load, ld_valid on every other cycle
      rst256 = 1'b1;
      tick;
      rst256 = 1'b0;
      for (int i = 0; i < 6; i++) begin
         drv256((i % 2) == 0, 32'hA000_0000 + 32'(i), i == 4);
         want(0, K_CNT, 32'(THR_CNT[i]), $sformatf("thr_cnt_%0d", i));
         want(0, K_IDATA, (i == 5) ? 32'hA000_0000 : 32'h0, $sformatf("thr_idata_%0d", i));
         want(0, K_CRST, (i == 5) ? 32'd0 : 32'd1, $sformatf("thr_crst_%0d", i));
         tick;
      end
      drv256(1'b0, 32'h0, 1'b0);
      bus256.iaddr = 32'd4;
      want(0, K_CNT, 32'd3, "thr_cnt_final");
      want(0, K_IDATA, 32'hA000_0002, "thr_addr4");
      tick;
      bus256.iaddr = 32'd8;
      want(0, K_IDATA, 32'hA000_0004, "thr_addr8");
      tick;
      bus256.iaddr = 32'd0;
      want(0, K_FAULT, 32'd0, "thr_fault_clean");
      tick;

      // Reset in the middle of a load
      rst256 = 1'b1;
      tick;
      rst256 = 1'b0;
      drv256(1'b1, 32'hB000_0001, 1'b0);
      tick;
      drv256(1'b1, 32'hB000_0002, 1'b0);
      want(0, K_CNT, 32'd1, "mid_cnt1");
      tick;
      rst256 = 1'b1;
      drv256(1'b1, 32'hB000_0003, 1'b0);
      want(0, K_CNT, 32'd2, "mid_cnt2");
      tick;
      rst256 = 1'b0;
      drv256(1'b1, 32'hC000_0001, 1'b1);
      want(0, K_CNT, 32'd0, "mid_cnt_cleared");
      want(0, K_CRST, 32'd1, "mid_crst");
      want(0, K_RDY, 32'd1, "mid_ready");
      tick;
      drv256(1'b0, 32'h0, 1'b0);
      bus256.iaddr = 32'd0;
      want(0, K_CNT, 32'd1, "mid_reload_cnt");
      want(0, K_CRST, 32'd0, "mid_reload_crst");
      want(0, K_IDATA, 32'hC000_0001, "mid_reload_addr0");
      tick;
      bus256.iaddr = 32'd4;
      want(0, K_IDATA, 32'h0, "mid_stale_masked");
      tick;
      bus256.iaddr = 32'd0;
      want(0, K_FAULT, 32'(FE), "mid_fault_stale");
      tick;

`ifdef IMEM_FAULT_EN
      // Fault detection and stickiness
      rst256 = 1'b1;
      tick;
      rst256 = 1'b0;
      drv256(1'b1, 32'hD000_0001, 1'b0);
      tick;
      drv256(1'b1, 32'hD000_0002, 1'b1);
      tick;
      drv256(1'b0, 32'h0, 1'b0);
      bus256.iaddr = 32'd0;
      want(0, K_IDATA, 32'hD000_0001, "flt_addr0");
      want(0, K_FAULT, 32'd0, "flt_clean");
      tick;
      bus256.iaddr = 32'd6;
      want(0, K_IDATA, 32'hD000_0002, "flt_misalign_data");
      want(0, K_FAULT, 32'd0, "flt_before_edge");
      tick;
      bus256.iaddr = 32'd0;
      want(0, K_FAULT, 32'd1, "flt_misalign_set");
      tick;
      bus256.iaddr = 32'h400;
      want(0, K_FAULT, 32'd1, "flt_sticky");
      want(0, K_IDATA, 32'h0, "flt_oob_nop");
      tick;
      bus256.iaddr = 32'd0;
      rst256 = 1'b1;
      tick;
      rst256 = 1'b0;
      want(0, K_FAULT, 32'd0, "flt_reset_clears");
      tick;
`endif

      // DEPTH=4: five words offered with no ld_last
      rst4 = 1'b0;
      want(1, K_CNT, 32'd0, "d4_rst_cnt");
      want(1, K_CRST, 32'd1, "d4_rst_crst");
      want(1, K_IDATA, 32'h0, "d4_rst_idata");
      tick;
      for (int i = 0; i < 5; i++) begin
         drv4(1'b1, 32'hE000_0000 + 32'(i), 1'b0);
         want(1, K_CNT, 32'(i), $sformatf("d4_cnt_%0d", i));
         want(1, K_RDY, (i < 4) ? 32'd1 : 32'd0, $sformatf("d4_rdy_%0d", i));
         tick;
      end
      drv4(1'b0, 32'h0, 1'b0);
      bus4.iaddr = 32'd0;
      want(1, K_CNT, 32'd4, "d4_cnt_sat");
      want(1, K_CRST, 32'd0, "d4_crst");
      want(1, K_IDATA, 32'hE000_0000, "d4_addr0_no_5th");
      tick;
      bus4.iaddr = 32'd4;
      want(1, K_IDATA, 32'hE000_0001, "d4_addr4");
      tick;
      bus4.iaddr = 32'd8;
      want(1, K_IDATA, 32'hE000_0002, "d4_addr8");
      tick;
      bus4.iaddr = 32'd12;
      want(1, K_IDATA, 32'hE000_0003, "d4_addr12");
      want(1, K_FAULT, 32'd0, "d4_fault_clean");
      tick;
      bus4.iaddr = 32'd5;
      want(1, K_IDATA, 32'hE000_0001, "d4_low_bits_ignored");
      tick;
      bus4.iaddr = 32'd16;
      want(1, K_IDATA, FE ? 32'h0 : 32'hE000_0000, "d4_addr16");
      tick;
      bus4.iaddr = 32'd0;
      want(1, K_FAULT, 32'(FE), "d4_fault_final");
      tick;

      tick;
      if (sb.size() != 0) begin
         n_bad++;
         $display("FAIL drain: got %0d pending, want 0", sb.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
